// File: rtl/color_detect_pkg.sv
// Shared types and defaults for the color-detection frame scanner.
// Holds the scan FSM state type and frame geometry defaults.
package color_detect_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCAN,
    ST_DRAIN,
    ST_LATCH
  } scan_state_t;

  localparam int NPIX_DEF   = 76800;
  localparam int ADDR_W_DEF = 18;
  localparam int PIX_W      = 16;

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep {valid, addr} tag pipe matching frame-buffer read latency.
// Ports: i_clk, i_rst, i_valid/i_addr in, o_valid/o_addr at stage RD_LAT.
module rd_tag_pipe #(
  parameter int ADDR_W = 18,
  parameter int RD_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr
);

  logic [RD_LAT-1:0] vld;
  logic [ADDR_W-1:0] adr [RD_LAT];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++)
        adr[i] <= '0;
    end else begin
      vld[0] <= i_valid;
      adr[0] <= i_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        adr[i] <= adr[i-1];
      end
    end
  end

  assign o_valid = vld[RD_LAT-1];
  assign o_addr  = adr[RD_LAT-1];

endmodule

// File: rtl/color_scan_ctrl.sv
// Frame-scan sequencer: clear bins, read frame, stream pixels, drain, latch.
// Ports: frame_done/enable in, granted read port, pixel stream, status counters.
module color_scan_ctrl
  import color_detect_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NPIX   = NPIX_DEF,
  parameter int RD_LAT = 2,
  parameter int DRAIN  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_frame_done,
  output logic              o_rd_req,
  input  logic              i_rd_gnt,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [PIX_W-1:0]  i_rd_data,
  output logic [PIX_W-1:0]  o_pix_data,
  output logic [ADDR_W-1:0] o_pix_addr,
  output logic              o_pix_valid,
  output logic              o_bin_clear,
  output logic              o_result_latch,
  output logic              o_busy,
  output logic [7:0]        o_frame_cnt,
  output logic [7:0]        o_drop_cnt
);

  // Extra count bit lets NPIX == 2^ADDR_W terminate.
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] NPIX_C = CW'(NPIX);
  localparam logic [CW-1:0] LAST   = CW'(NPIX - 1);
  localparam int DLEN = RD_LAT + 1 + DRAIN;
  localparam int DW   = $clog2(DLEN + 1);
  localparam logic [DW-1:0] DEND = DW'(DLEN - 1);

  scan_state_t state, state_nxt;

  logic [CW-1:0]     issue_cnt;
  logic [DW-1:0]     drain_cnt;
  logic              pend;
  logic [7:0]        frame_cnt;
  logic [7:0]        drop_cnt;
  logic              accept;
  logic              start;
  logic              consume;
  logic              tag_v;
  logic [ADDR_W-1:0] tag_a;

  assign o_rd_req  = (state == ST_SCAN) && (issue_cnt < NPIX_C);
  assign accept    = o_rd_req & i_rd_gnt;
  assign start     = (i_frame_done | pend) & i_enable;
  assign o_rd_addr = issue_cnt[ADDR_W-1:0];

  // A pending request is consumed whenever a new frame is launched.
  assign consume = (state_nxt == ST_CLEAR) &&
                   ((state == ST_IDLE) || (state == ST_LATCH));

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = ST_SCAN;
      ST_SCAN:  if (accept && issue_cnt == LAST)
                  state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == DEND)
                  state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = start ? ST_CLEAR : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      issue_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      if (state == ST_CLEAR)
        issue_cnt <= '0;
      else if (accept)
        issue_cnt <= issue_cnt + 1'b1;
      if (state != ST_DRAIN)
        drain_cnt <= '0;
      else
        drain_cnt <= drain_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend      <= 1'b0;
      drop_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      if (consume)
        pend <= 1'b0;
      else if (state != ST_IDLE && i_frame_done)
        pend <= 1'b1;
      if (state != ST_IDLE && i_frame_done &&
          pend && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      if (state == ST_LATCH)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

  rd_tag_pipe #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_tag (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (accept),
    .i_addr  (o_rd_addr),
    .o_valid (tag_v),
    .o_addr  (tag_a)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pix_valid <= 1'b0;
      o_pix_data  <= '0;
      o_pix_addr  <= '0;
    end else begin
      o_pix_valid <= tag_v;
      if (tag_v) begin
        o_pix_data <= i_rd_data;
        o_pix_addr <= tag_a;
      end
    end
  end

  assign o_bin_clear    = (state == ST_CLEAR);
  assign o_result_latch = (state == ST_LATCH);
  assign o_busy         = (state != ST_IDLE);
  assign o_frame_cnt    = frame_cnt;
  assign o_drop_cnt     = drop_cnt;

endmodule

// File: tb/tb_color_scan_ctrl.sv
// Directed bench for color_scan_ctrl with a pixel scoreboard.
// Frame buffer is modelled as a fixed two-cycle read pipe.
module tb_color_scan_ctrl;

  localparam int AW = 2;
  localparam int NP = 4;
  localparam int RL = 2;
  localparam int DR = 3;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_enable = 1'b1;
  logic          i_frame_done = 1'b0;
  logic          i_rd_gnt = 1'b1;
  logic          o_rd_req;
  logic [AW-1:0] o_rd_addr;
  logic [15:0]   i_rd_data;
  logic [15:0]   o_pix_data;
  logic [AW-1:0] o_pix_addr;
  logic          o_pix_valid;
  logic          o_bin_clear;
  logic          o_result_latch;
  logic          o_busy;
  logic [7:0]    o_frame_cnt;
  logic [7:0]    o_drop_cnt;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pix_cnt = 0;
  int   lat_cnt = 0;
  logic gmode = 1'b0;
  logic [3:0] gpat = 4'b1001;
  exp_t sbq[$];
  exp_t e;

  logic          m1v, m2v;
  logic [AW-1:0] m1a, m2a;

  color_scan_ctrl #(
    .ADDR_W (AW),
    .NPIX   (NP),
    .RD_LAT (RL),
    .DRAIN  (DR)
  ) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_enable       (i_enable),
    .i_frame_done   (i_frame_done),
    .o_rd_req       (o_rd_req),
    .i_rd_gnt       (i_rd_gnt),
    .o_rd_addr      (o_rd_addr),
    .i_rd_data      (i_rd_data),
    .o_pix_data     (o_pix_data),
    .o_pix_addr     (o_pix_addr),
    .o_pix_valid    (o_pix_valid),
    .o_bin_clear    (o_bin_clear),
    .o_result_latch (o_result_latch),
    .o_busy         (o_busy),
    .o_frame_cnt    (o_frame_cnt),
    .o_drop_cnt     (o_drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_f(input logic [AW-1:0] a);
    return (16'h1234 * (16'(a) + 16'd1)) ^ 16'h0F0F;
  endfunction

  always @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      m1v <= 1'b0; m2v <= 1'b0;
      m1a <= '0;   m2a <= '0;
    end else begin
      m1v <= o_rd_req & i_rd_gnt;
      m1a <= o_rd_addr;
      m2v <= m1v;
      m2a <= m1a;
    end
  end

  assign i_rd_data = m2v ? mem_f(m2a) : 16'hDEAD;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!i_rst && o_rd_req && i_rd_gnt)
      sbq.push_back('{addr: o_rd_addr,
                      data: mem_f(o_rd_addr),
                      cyc:  cyc + RL + 1});
  end

  always @(negedge clk) begin
    if (o_result_latch) lat_cnt++;
    if (o_pix_valid) begin
      pix_cnt++;
      chk("pix_pending", 32'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("pix_addr", 32'(o_pix_addr), 32'(e.addr));
        chk("pix_data", 32'(o_pix_data), 32'(e.data));
        chk("pix_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (gmode) i_rd_gnt = gpat[cyc[1:0]];
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (o_busy && n < bound);
    chk("idle_timeout", 32'(o_busy), 0);
  endtask

  task automatic wait_req(input int bound);
    int n;
    n = 0;
    while (!o_rd_req && n < bound) begin
      step();
      n++;
    end
    chk("req_timeout", 32'(o_rd_req), 1);
  endtask

  task automatic pulse_fd();
    i_frame_done = 1'b1;
    step();
    i_frame_done = 1'b0;
  endtask

  initial begin
    int t, p0, n, exp_frames, lat0;
    exp_frames = 0;

    // reset state
    repeat (2) step();
    chk("rst_req", 32'(o_rd_req), 0);
    chk("rst_pixv", 32'(o_pix_valid), 0);
    chk("rst_clr", 32'(o_bin_clear), 0);
    chk("rst_lat", 32'(o_result_latch), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_addr", 32'(o_rd_addr), 0);
    chk("rst_fcnt", 32'(o_frame_cnt), 0);
    chk("rst_dcnt", 32'(o_drop_cnt), 0);
    i_rst = 1'b0;
    step();

    // cycle-exact frame, grant high
    i_frame_done = 1'b1;
    t = cyc;
    for (int k = 1; k <= 13; k++) begin
      step();
      i_frame_done = 1'b0;
      chk("t_clr", 32'(o_bin_clear), 32'(cyc == t + 1));
      chk("t_req", 32'(o_rd_req),
          32'(cyc >= t + 2 && cyc <= t + 1 + NP));
      chk("t_lat", 32'(o_result_latch), 32'(cyc == t + 12));
      chk("t_busy", 32'(o_busy),
          32'(cyc >= t + 1 && cyc <= t + 12));
      if (cyc >= t + 2 && cyc <= t + 1 + NP)
        chk("t_addr", 32'(o_rd_addr), cyc - (t + 2));
    end
    exp_frames++;
    chk("t_fcnt", 32'(o_frame_cnt), exp_frames);
    chk("t_sbq", sbq.size(), 0);

    // grant stalls
    p0 = pix_cnt;
    gmode = 1'b1;
    pulse_fd();
    wait_idle(80);
    gmode = 1'b0;
    i_rd_gnt = 1'b1;
    exp_frames++;
    chk("g_npix", pix_cnt - p0, NP);
    chk("g_fcnt", 32'(o_frame_cnt), exp_frames);
    chk("g_sbq", sbq.size(), 0);

    // disabled frame_done in IDLE is ignored
    i_enable = 1'b0;
    pulse_fd();
    for (int k = 0; k < 4; k++) begin
      chk("dis_clr", 32'(o_bin_clear), 0);
      chk("dis_busy", 32'(o_busy), 0);
      step();
    end
    chk("dis_drop", 32'(o_drop_cnt), 0);

    // enable dropped mid-scan, pending frame held
    i_enable = 1'b1;
    pulse_fd();
    wait_req(10);
    i_enable = 1'b0;
    step();
    pulse_fd();
    wait_idle(40);
    exp_frames++;
    chk("en_fcnt", 32'(o_frame_cnt), exp_frames);
    repeat (3) step();
    chk("en_hold", 32'(o_busy), 0);
    i_enable = 1'b1;
    step();
    chk("en_pend", 32'(o_bin_clear), 1);
    wait_idle(40);
    exp_frames++;
    chk("en_fcnt2", 32'(o_frame_cnt), exp_frames);

    // three frame_done pulses while busy
    pulse_fd();
    wait_req(10);
    step();
    pulse_fd();
    step();
    pulse_fd();
    step();
    pulse_fd();
    chk("drop2", 32'(o_drop_cnt), 2);
    n = 0;
    while (!o_result_latch && n < 40) begin
      step();
      n++;
    end
    chk("b2b_lat", 32'(o_result_latch), 1);
    step();
    chk("b2b_clr", 32'(o_bin_clear), 1);
    chk("b2b_busy", 32'(o_busy), 1);
    wait_idle(40);
    exp_frames += 2;
    chk("b2b_fcnt", 32'(o_frame_cnt), exp_frames);
    chk("b2b_sbq", sbq.size(), 0);

    // reset mid-scan with reads in flight
    pulse_fd();
    step();
    step();
    i_rst = 1'b1;
    sbq.delete();
    #1;
    chk("mr_req", 32'(o_rd_req), 0);
    chk("mr_pixv", 32'(o_pix_valid), 0);
    chk("mr_busy", 32'(o_busy), 0);
    chk("mr_addr", 32'(o_rd_addr), 0);
    chk("mr_pdata", 32'(o_pix_data), 0);
    chk("mr_paddr", 32'(o_pix_addr), 0);
    chk("mr_fcnt", 32'(o_frame_cnt), 0);
    chk("mr_dcnt", 32'(o_drop_cnt), 0);
    step();
    step();
    i_rst = 1'b0;
    p0 = pix_cnt;
    repeat (6) step();
    chk("mr_stray", pix_cnt - p0, 0);
    pulse_fd();
    wait_req(10);
    chk("mr_addr0", 32'(o_rd_addr), 0);
    wait_idle(40);
    chk("mr_fcnt1", 32'(o_frame_cnt), 1);

    // frame counter wrap and drop saturation
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    step();
    lat0 = lat_cnt;
    i_frame_done = 1'b1;
    n = 0;
    while (lat_cnt - lat0 < 256 && n < 5000) begin
      step();
      n++;
    end
    chk("w_nlat", lat_cnt - lat0, 256);
    chk("w_wrap", 32'(o_frame_cnt), 0);
    chk("w_sat", 32'(o_drop_cnt), 255);
    i_frame_done = 1'b0;
    wait_idle(100);
    chk("w_fcnt", 32'(o_frame_cnt), 32'(8'(lat_cnt - lat0)));
    chk("w_sat2", 32'(o_drop_cnt), 255);
    chk("w_sbq", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/color_scan_ctrl.md
# color_scan_ctrl

Frame-scan sequencer for the color-detection datapath. After each frame is captured, it reads the frame buffer pixel by pixel through a shared, granted read port. It streams each pixel and its address into the HSV/color-bin pipeline with a valid strobe, then waits for the pipeline to drain. It brackets every frame with a bin-clear pulse before the scan and a result-latch pulse after the drain.

## Interface
Parameters:
- ADDR_W, 18, pixel address width
- NPIX, 76800, pixels per frame (320x240); must be ≥ 1 and ≤ 2^ADDR_W
- RD_LAT, 2, frame-buffer read latency in cycles from accepted request to valid i_rd_data; ≥ 1
- DRAIN, 16, cycles allowed for the HSV/bin pipeline to flush after the last pixel

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; one clock, asynchronous, active-high
- i_enable  in  1  allows new frames to start
- i_frame_done  in  1  one-cycle pulse: a new frame has been written to the buffer
- o_rd_req  out  1  frame-buffer read request
- i_rd_gnt  in  1  read granted this cycle; a read is accepted when o_rd_req & i_rd_gnt
- o_rd_addr  out  ADDR_W  read address, valid while o_rd_req
- i_rd_data  in  16  RGB565 read data
- o_pix_data  out  16  pixel to pipeline
- o_pix_addr  out  ADDR_W  address of o_pix_data
- o_pix_valid  out  1  pixel strobe
- o_bin_clear  out  1  one-cycle pulse before each scan
- o_result_latch  out  1  one-cycle pulse after drain
- o_busy  out  1  state ≠ IDLE
- o_frame_cnt  out  8  completed frames, wraps
- o_drop_cnt  out  8  dropped frame_done pulses, saturates at 255

## Operation
- FSM states: IDLE, CLEAR, SCAN, DRAIN, LATCH.
- IDLE → CLEAR: on (i_frame_done | pend) & i_enable. pend is cleared on entry to CLEAR.
- CLEAR → SCAN: after one cycle. o_bin_clear = (state==CLEAR).
- SCAN behaviour:
  - o_rd_req = 1 while issue count < NPIX.
  - o_rd_addr = issue count, starting at 0; it increments only on an accepted read.
  - Leaves SCAN in the cycle after the NPIX-th accept.
- DRAIN: counts RD_LAT+1+DRAIN cycles, then moves to LATCH.
- LATCH: o_result_latch = 1 for one cycle and o_frame_cnt increments.
  - Goes to CLEAR if (pend | i_frame_done) & i_enable; otherwise goes to IDLE.
- Return path:
  - A tag shift register, RD_LAT deep, carries {accepted, addr}.
  - At stage RD_LAT, i_rd_data and the addr are registered into o_pix_data and o_pix_addr, and o_pix_valid = 1.
  - Every accepted read produces exactly one o_pix_valid, in order.
- Frame arriving while busy:
  - i_frame_done while busy with pend=0 sets pend.
  - With pend=1 already set, o_drop_cnt increments (saturating).
  - i_frame_done in IDLE with i_enable=0 is ignored and not counted.
- i_enable deasserted mid-frame: the current frame completes. pend is held, not cleared.
- Simultaneous events: i_frame_done in LATCH is treated as pend, so LATCH goes directly to CLEAR.
- Arithmetic: the issue counter is ADDR_W+1 bits wide, so NPIX = 2^ADDR_W terminates correctly.

## Timing
- Reset values: o_rd_req, o_pix_valid, o_bin_clear, o_result_latch and o_busy are 0; o_rd_addr, o_pix_data, o_pix_addr, o_frame_cnt and o_drop_cnt are 0; state is IDLE; pend is 0; the tag pipe is empty.
- Reset mid-operation: all in-flight tags are discarded. No o_pix_valid follows reset.
- With i_frame_done at cycle t in IDLE and grant tied high:
  - o_bin_clear at t+1
  - o_rd_req from t+2 to t+1+NPIX
  - first o_pix_valid at t+3+RD_LAT
  - last o_pix_valid at t+2+NPIX+RD_LAT
  - o_result_latch at t+3+NPIX+RD_LAT+DRAIN
- Grant stalls insert bubbles in o_pix_valid. Latency per pixel stays fixed at RD_LAT+1 from accept.
- All outputs are registered or decoded directly from registered state. There are no combinational paths from inputs to outputs.

## Structure
- Package color_detect_pkg holds:
  - the state enum `scan_state_t`
  - default constants for NPIX and ADDR_W
  - a constant PIX_W = 16
- Sub-module rd_tag_pipe: parameterised RD_LAT-deep shift register of {valid, addr}, with async clear on i_rst.
- The top level holds the FSM, the counters, pend and the output registers.

## Test plan
- NPIX=4, RD_LAT=2, DRAIN=3, grant high, frame_done at t=10:
  - bin_clear at 11
  - rd_req over 12–15 with addrs 0–3
  - pix_valid over 15–18 with matching data and addrs
  - result_latch at 22
  - frame_cnt=1
- Grant toggled 1,0,0,1,…: exactly NPIX pix_valid pulses, addresses consecutive, each data item RD_LAT+1 cycles after its accept.
- Three frame_done pulses during SCAN: pend set, drop_cnt=2; the second frame starts in the cycle after LATCH with no IDLE cycle.
- i_enable=0 with frame_done in IDLE: no bin_clear, busy stays 0, drop_cnt=0. Dropping i_enable mid-SCAN: the frame still latches.
- i_rst asserted mid-SCAN with reads in flight: outputs are at reset values immediately, no stray pix_valid, and the next frame_done restarts at addr 0.
- frame_cnt wraps 255→0 after 256 frames; drop_cnt saturates at 255.
